// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Receiving side of a multiplexed, active-low 7-segment scan. Rebuilds the
//   NDIG-digit hex value being displayed, flags blank digits, and records any
//   illegal segment pattern.
//
//   Optional build macro SEG7_SCAN_TIMEOUT_EN adds a capture watchdog that
//   raises Stale and drops the partial frame after TIMEOUT_CYCLES without a
//   digit capture. Without the macro Stale is constant 0.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   Segments   active-low segments, bit0=a .. bit6=g
//   Anodes     active-low digit enables, exactly one low selects a digit
//   Value      last complete frame, digit i in bits [4i+3:4i]
//   BlankMask  bit i set when digit i was blank in the last frame
//   FrameValid one-cycle pulse when Value/BlankMask update
//   SegErr     sticky illegal non-blank pattern flag
//   Stale      no capture within TIMEOUT_CYCLES (timeout build only)
module seg7_scan_decoder #(
  parameter int unsigned NDIG           = 8,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        Segments,
  input  logic [NDIG-1:0]   Anodes,
  output logic [4*NDIG-1:0] Value,
  output logic [NDIG-1:0]   BlankMask,
  output logic              FrameValid,
  output logic              SegErr,
  output logic              Stale
);

  localparam int unsigned IW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0]  STABLE = STABLE_CYCLES[7:0];

  typedef enum logic [1:0] {
    S_WAIT,
    S_COUNT,
    S_HELD
  } state_t;

  state_t state, state_nx;

  logic [NDIG-1:0]   a_r, a_p;
  logic [6:0]        s_r, s_p;
  logic [7:0]        cnt, cnt_nx;
  logic [NDIG-1:0]   na;
  logic              valid, same, cap;
  logic [IW-1:0]     idx;
  logic [6:0]        pat;
  logic [3:0]        nib;
  logic              blank, illegal;
  logic [NDIG-1:0]   seen, seen_nx;
  logic              complete;
  logic [4*NDIG-1:0] fbuf;
  logic [NDIG-1:0]   bbuf;
  logic              tmo_hit;

  // Anode qualification and digit index on the registered sample
  assign na    = ~a_r;
  assign valid = (na != '0) && ((na & (na - 1'b1)) == '0);
  assign same  = (a_r == a_p) && (s_r == s_p);
  assign pat   = ~s_r;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!a_r[i]) idx = i[IW-1:0];
    end
  end

  always_comb begin
    nib     = '0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (pat)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      7'h00: blank = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Dwell FSM: HELD blocks recapture of a sample that has already been taken
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    case (state)
      S_WAIT: begin
        if (valid) begin
          state_nx = S_COUNT;
          cnt_nx   = 8'd1;
        end
      end
      S_COUNT: begin
        if (!valid) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end else if (same) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx = 8'd1;
        end
      end
      S_HELD: begin
        if (!valid) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end else if (!same) begin
          state_nx = S_COUNT;
          cnt_nx   = 8'd1;
        end
      end
      default: begin
        state_nx = S_WAIT;
        cnt_nx   = '0;
      end
    endcase
    // Threshold check after the transition so STABLE_CYCLES=1 captures on entry
    if (state_nx == S_COUNT && cnt_nx == STABLE) begin
      cap      = 1'b1;
      state_nx = S_HELD;
    end
  end

  // Frame completion clears seen on the same edge a new capture may set a bit
  always_comb begin
    complete = &seen;
    seen_nx  = complete ? '0 : seen;
    if (cap) seen_nx[idx] = 1'b1;
    if (tmo_hit) seen_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r        <= '1;
      s_r        <= '1;
      a_p        <= '1;
      s_p        <= '1;
      state      <= S_WAIT;
      cnt        <= '0;
      seen       <= '0;
      fbuf       <= '0;
      bbuf       <= '0;
      Value      <= '0;
      BlankMask  <= '0;
      FrameValid <= 1'b0;
      SegErr     <= 1'b0;
    end else begin
      a_r        <= Anodes;
      s_r        <= Segments;
      a_p        <= a_r;
      s_p        <= s_r;
      state      <= state_nx;
      cnt        <= cnt_nx;
      seen       <= seen_nx;
      FrameValid <= complete;
      if (complete) begin
        Value     <= fbuf;
        BlankMask <= bbuf;
      end
      if (cap) begin
        fbuf[{idx, 2'b00} +: 4] <= nib;
        bbuf[idx]               <= blank;
        if (illegal) SegErr <= 1'b1;
      end
    end
  end

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TIMEOUT_CYCLES[TW-1:0];

  logic [TW-1:0] tcnt;

  assign tmo_hit = !cap && (tcnt != TLIM) && ((tcnt + 1'b1) == TLIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt  <= '0;
      Stale <= 1'b0;
    end else if (cap) begin
      tcnt  <= '0;
      Stale <= 1'b0;
    end else begin
      if (tcnt != TLIM) tcnt <= tcnt + 1'b1;
      if (tmo_hit) Stale <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES has no effect without the watchdog; the term folds to 0
  assign Stale   = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule
